// File: rtl/config_loader.sv
// Streaming configuration loader: a header word selects a target memory, a start
// address and a payload length; each payload word becomes one registered write strobe.
module config_loader #(
    parameter int DSIZE                   = 16,
    parameter int NURN_CNT_BIT_WIDTH      = 8,
    parameter int AXON_CNT_BIT_WIDTH      = 8,
    parameter int CONFIG_PARAMETER_NUMBER = 9
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic                                           ce_i,
    input  logic                                           cfg_valid_i,
    input  logic [DSIZE*2-1:0]                             cfg_data_i,
    output logic                                           cfg_ready_o,
    output logic [DSIZE*2-1:0]                             config_data_out_o,
    output logic [CONFIG_PARAMETER_NUMBER-1:0]             config_write_enable_o,
    output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] config_addr_o,
    output logic                                           busy_o,
    output logic                                           done_o,
    output logic                                           err_o,
    input  logic                                           err_clr_i
);

    localparam int WW      = DSIZE * 2;
    localparam int AW      = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
    localparam int SEL_W   = 4;
    localparam int LEN_W   = 8;
    localparam int CPN     = CONFIG_PARAMETER_NUMBER;
    localparam int SEL_LSB = WW - SEL_W;
    localparam int LEN_LSB = SEL_LSB - LEN_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATA    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [AW-1:0]        r_addr;
    logic [AW-1:0]        w_addr_nxt;
    logic [LEN_W-1:0]     r_cnt;
    logic [LEN_W-1:0]     w_cnt_nxt;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic [CPN-1:0]       r_we;
    logic [CPN-1:0]       w_we_nxt;
    logic [WW-1:0]        r_data_out;
    logic [WW-1:0]        w_data_out_nxt;
    logic [AW-1:0]        r_addr_out;
    logic [AW-1:0]        w_addr_out_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic                 w_err_set;

    logic                 w_xfer;
    logic [SEL_W-1:0]     w_hdr_sel;
    logic [LEN_W-1:0]     w_hdr_len_m1;
    logic [AW-1:0]        w_hdr_addr;
    logic                 w_hdr_sel_ok;
    logic [CPN-1:0]       w_sel_onehot;
    logic                 w_last;

    assign cfg_ready_o  = ce_i & ~rst_i;
    assign w_xfer       = cfg_valid_i & cfg_ready_o;

    assign w_hdr_sel    = cfg_data_i[SEL_LSB +: SEL_W];
    assign w_hdr_len_m1 = cfg_data_i[LEN_LSB +: LEN_W];
    assign w_hdr_addr   = cfg_data_i[AW-1:0];
    assign w_hdr_sel_ok = (32'(w_hdr_sel) < 32'(CPN));
    assign w_sel_onehot = {{(CPN-1){1'b0}}, 1'b1} << r_sel;
    assign w_last       = (r_cnt == {LEN_W{1'b0}});

    // Next-state and next-datapath values; a write is launched only on an accepted payload word.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_cnt_nxt      = r_cnt;
        w_sel_nxt      = r_sel;
        w_we_nxt       = {CPN{1'b0}};
        w_data_out_nxt = r_data_out;
        w_addr_out_nxt = r_addr_out;
        w_done_nxt     = 1'b0;
        w_err_set      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_addr_nxt = w_hdr_addr;
                    w_cnt_nxt  = w_hdr_len_m1;
                    w_sel_nxt  = w_hdr_sel;
                    if (w_hdr_sel_ok) begin
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                        w_err_set   = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_xfer) begin
                    w_we_nxt       = w_sel_onehot;
                    w_data_out_nxt = cfg_data_i;
                    w_addr_out_nxt = r_addr;
                    w_addr_nxt     = r_addr + {{(AW-1){1'b0}}, 1'b1};
                    w_cnt_nxt      = r_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DISCARD: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt - {{(LEN_W-1){1'b0}}, 1'b1};
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                    end
                end else begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A bad-selector header wins over a simultaneous clear request.
        if (w_err_set) begin
            w_err_nxt = 1'b1;
        end else if (err_clr_i) begin
            w_err_nxt = 1'b0;
        end else begin
            w_err_nxt = r_err;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, strobe and status registers; reset drops any pending strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr     <= {AW{1'b0}};
            r_cnt      <= {LEN_W{1'b0}};
            r_sel      <= {SEL_W{1'b0}};
            r_we       <= {CPN{1'b0}};
            r_data_out <= {WW{1'b0}};
            r_addr_out <= {AW{1'b0}};
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_addr     <= w_addr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sel      <= w_sel_nxt;
            r_we       <= w_we_nxt;
            r_data_out <= w_data_out_nxt;
            r_addr_out <= w_addr_out_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign config_write_enable_o = r_we;
    assign config_data_out_o     = r_data_out;
    assign config_addr_o         = r_addr_out;
    assign busy_o                = (r_state != ST_IDLE);
    assign done_o                = r_done;
    assign err_o                 = r_err;

endmodule

// File: tb/tb_config_loader.sv
// Directed and randomized bench for config_loader, checked against a packet-level model.
module tb_config_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ce_i;
    logic        cfg_valid_i;
    logic [31:0] cfg_data_i;
    logic        cfg_ready_o;
    logic [31:0] config_data_out_o;
    logic [8:0]  config_write_enable_o;
    logic [15:0] config_addr_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        err_clr_i;

    int checks   = 0;
    int failures = 0;

    // Packet-level reference model state
    bit          m_in_pkt;
    bit          m_good;
    int          m_sel;
    int          m_left;
    int          m_addr;
    bit          m_err;
    logic [31:0] m_last_data;
    int          m_last_addr;

    always #5 clk_i = ~clk_i;

    config_loader dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .ce_i                  (ce_i),
        .cfg_valid_i           (cfg_valid_i),
        .cfg_data_i            (cfg_data_i),
        .cfg_ready_o           (cfg_ready_o),
        .config_data_out_o     (config_data_out_o),
        .config_write_enable_o (config_write_enable_o),
        .config_addr_o         (config_addr_o),
        .busy_o                (busy_o),
        .done_o                (done_o),
        .err_o                 (err_o),
        .err_clr_i             (err_clr_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in_pkt    = 1'b0;
        m_good      = 1'b0;
        m_sel       = 0;
        m_left      = 0;
        m_addr      = 0;
        m_err       = 1'b0;
        m_last_data = 32'h0;
        m_last_addr = 0;
    endtask

    // One clock cycle of stimulus, entered and left at posedge+1.
    task automatic step(input logic v, input logic [31:0] w, input logic ce, input logic clr);
        logic [8:0] e_we;
        logic       e_done;
        cfg_valid_i = v;
        cfg_data_i  = w;
        ce_i        = ce;
        err_clr_i   = clr;
        e_we        = 9'd0;
        e_done      = 1'b0;
        @(negedge clk_i);
        chk("ready", {31'd0, cfg_ready_o}, {31'd0, ce});
        if (v && ce) begin
            if (!m_in_pkt) begin
                m_sel    = int'(w[31:28]);
                m_left   = int'(w[27:20]) + 1;
                m_addr   = int'(w[15:0]);
                m_good   = (m_sel < 9);
                m_in_pkt = 1'b1;
                if (!m_good) m_err = 1'b1;
                else if (clr) m_err = 1'b0;
            end else begin
                if (m_good) begin
                    e_we        = 9'd1 << m_sel;
                    m_last_addr = m_addr;
                    m_last_data = w;
                end
                m_addr = (m_addr + 1) % 65536;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_in_pkt = 1'b0;
                    e_done   = 1'b1;
                end
                if (clr) m_err = 1'b0;
            end
        end else if (clr) begin
            m_err = 1'b0;
        end
        @(posedge clk_i);
        #1;
        cfg_valid_i = 1'b0;
        err_clr_i   = 1'b0;
        chk("strobe", {23'd0, config_write_enable_o}, {23'd0, e_we});
        chk("addr",   {16'd0, config_addr_o}, 32'(m_last_addr));
        chk("data",   config_data_out_o, m_last_data);
        chk("done",   {31'd0, done_o}, {31'd0, e_done});
        chk("busy",   {31'd0, busy_o}, {31'd0, m_in_pkt});
        chk("err",    {31'd0, err_o},  {31'd0, m_err});
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        ce_i        = 1'b1;
        cfg_valid_i = 1'b1;
        cfg_data_i  = 32'h1000_0000;
        @(negedge clk_i);
        chk("ready_in_reset", {31'd0, cfg_ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        cfg_valid_i = 1'b0;
        model_reset();
        chk("rst_strobe", {23'd0, config_write_enable_o}, 32'd0);
        chk("rst_addr",   {16'd0, config_addr_o}, 32'd0);
        chk("rst_data",   config_data_out_o, 32'd0);
        chk("rst_busy",   {31'd0, busy_o}, 32'd0);
        chk("rst_done",   {31'd0, done_o}, 32'd0);
        chk("rst_err",    {31'd0, err_o},  32'd0);
    endtask

    initial begin
        logic [3:0]  r_sel;
        logic [7:0]  r_len;
        logic [15:0] r_addr;
        logic [3:0]  r_rsv;
        rst_i       = 1'b1;
        ce_i        = 1'b1;
        cfg_valid_i = 1'b0;
        cfg_data_i  = 32'h0;
        err_clr_i   = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        do_reset();

        // Three-word packet to target 2 at 0x0010
        step(1'b1, 32'h2020_0010, 1'b1, 1'b0);
        step(1'b1, 32'h0000_000A, 1'b1, 1'b0);
        step(1'b1, 32'h0000_000B, 1'b1, 1'b0);
        step(1'b1, 32'h0000_000C, 1'b1, 1'b0);
        chk("req33_last_addr", {16'd0, config_addr_o}, 32'h0000_0012);
        chk("req33_done", {31'd0, done_o}, 32'd1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Top target, single word at 0xFFFF, then two words wrapping to 0x0000
        step(1'b1, 32'h8000_FFFF, 1'b1, 1'b0);
        step(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        chk("req34_single_we", {23'd0, config_write_enable_o}, 32'h0000_0100);
        step(1'b1, 32'h8010_FFFF, 1'b1, 1'b0);
        step(1'b1, 32'hAAAA_0001, 1'b1, 1'b0);
        step(1'b1, 32'hAAAA_0002, 1'b1, 1'b0);
        chk("req34_wrap_addr", {16'd0, config_addr_o}, 32'h0000_0000);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Bad selector: discarded payload, sticky error, then clear
        step(1'b1, 32'hC010_0000, 1'b1, 1'b0);
        step(1'b1, 32'h5555_5555, 1'b1, 1'b0);
        step(1'b1, 32'h6666_6666, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Enable dropped for three cycles in the middle of a packet
        step(1'b1, 32'h1020_0100, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0111, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0222, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0222, 1'b1, 1'b0);
        chk("req36_addr2", {16'd0, config_addr_o}, 32'h0000_0101);
        step(1'b1, 32'h0000_0333, 1'b1, 1'b0);

        // Reset mid-packet; the next word is a fresh header
        step(1'b1, 32'h0030_0200, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0777, 1'b1, 1'b0);
        do_reset();
        step(1'b1, 32'h0000_0005, 1'b1, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        chk("req37_addr", {16'd0, config_addr_o}, 32'h0000_0005);
        chk("req37_we",   {23'd0, config_write_enable_o}, 32'h0000_0001);

        // Clear coinciding with a bad header: set wins
        step(1'b1, 32'hF000_0000, 1'b1, 1'b1);
        chk("req38_err", {31'd0, err_o}, 32'd1);
        step(1'b1, 32'h0BAD_0BAD, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);

        // Randomized packets with enable gaps, idle gaps and error clears
        for (int p = 0; p < 40; p++) begin
            r_sel  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            r_len  = 8'($urandom_range(0, 5));
            r_addr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom_range(0, 65535));
            r_rsv  = 4'($urandom_range(0, 15));
            step(1'b1, {r_sel, r_len, r_rsv, r_addr}, 1'b1, ($urandom_range(0, 7) == 0));
            for (int i = 0; i <= int'(r_len); i++) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    if ($urandom_range(0, 1) == 0) step(1'b1, $urandom, 1'b0, 1'b0);
                    else step(1'b0, $urandom, 1'b1, ($urandom_range(0, 9) == 0));
                end
                step(1'b1, $urandom, 1'b1, 1'b0);
            end
            if ($urandom_range(0, 2) == 0) step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
